// File: rtl/gray_counter_n.sv
// gray_counter_n: up/down Gray/binary counter with load, clear, optional saturation,
// a one-cycle wrap pulse and sticky overflow/underflow flags.
module gray_counter_n #(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Up,
    input  logic             Clr,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Value,
    input  logic             Clear_Flags,
    output logic [WIDTH-1:0] Gray,
    output logic [WIDTH-1:0] Binary,
    output logic             Wrap,
    output logic             Overflow,
    output logic             Underflow
);
    localparam logic [WIDTH-1:0] MAX = '1;
    logic [WIDTH-1:0] bin_q, bin_d, gray_q, gray_d;
    logic             wrap_q, wrap_d, ovf_q, ovf_d, unf_q, unf_d;
    logic             cnt, up_end, dn_end;
    always_comb begin
        cnt    = En & ~Clr & ~Load;
        up_end = cnt & Up & (bin_q == MAX);
        dn_end = cnt & ~Up & (bin_q == '0);
        bin_d  = Clr ? '0 :
                 Load ? Load_Value :
                 (SATURATE && (up_end || dn_end)) ? bin_q :
                 !En ? bin_q :
                 Up ? bin_q + 1'b1 : bin_q - 1'b1;
        // Gray is registered from next-B so it never glitches through a decoder
        gray_d = bin_d ^ (bin_d >> 1);
        wrap_d = !SATURATE && (up_end || dn_end);
        ovf_d  = up_end | (ovf_q & ~Clear_Flags);
        unf_d  = dn_end | (unf_q & ~Clear_Flags);
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end
    assign Gray      = gray_q;
    assign Binary    = bin_q;
    assign Wrap      = wrap_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
endmodule

// File: tb/tb_gray_counter_n.sv
// tb_gray_counter_n: three counter configurations driven in lockstep, checked by a
// queue-based scoreboard against an arithmetic reference model.
module tb_gray_counter_n;
    logic Clk = 1'b0;
    logic Reset_n = 1'b1;
    logic En = 0, Up = 0, Clr = 0, Load = 0, Clear_Flags = 0;
    logic [3:0] lv = '0;
    logic [2:0] g0, b0;
    logic [3:0] g1, b1, g2, b2;
    logic w0, o0, u0, w1, o1, u1, w2, o2, u2;
    int tests = 0, fails = 0;

    typedef struct packed {
        logic [3:0] g0, b0, g1, b1, g2, b2;
        logic [2:0] w, o, u;
    } exp_t;
    exp_t sb[$];

    int mb[3];
    bit mo[3], mu[3], mwr[3];
    int mw[3] = '{3, 4, 4};
    bit ms[3] = '{1'b0, 1'b1, 1'b0};

    always #5 Clk = ~Clk;

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) u0_dut (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Up(Up), .Clr(Clr), .Load(Load),
        .Load_Value(lv[2:0]), .Clear_Flags(Clear_Flags), .Gray(g0), .Binary(b0),
        .Wrap(w0), .Overflow(o0), .Underflow(u0));
    gray_counter_n #(.WIDTH(4), .SATURATE(1'b1)) u1_dut (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Up(Up), .Clr(Clr), .Load(Load),
        .Load_Value(lv), .Clear_Flags(Clear_Flags), .Gray(g1), .Binary(b1),
        .Wrap(w1), .Overflow(o1), .Underflow(u1));
    gray_counter_n #(.WIDTH(4), .SATURATE(1'b0)) u2_dut (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Up(Up), .Clr(Clr), .Load(Load),
        .Load_Value(lv), .Clear_Flags(Clear_Flags), .Gray(g2), .Binary(b2),
        .Wrap(w2), .Overflow(o2), .Underflow(u2));

    function automatic int to_gray(int v);
        return v ^ (v >> 1);
    endfunction

    function automatic exp_t snap();
        exp_t e;
        e.g0 = 4'(to_gray(mb[0])); e.b0 = 4'(mb[0]);
        e.g1 = 4'(to_gray(mb[1])); e.b1 = 4'(mb[1]);
        e.g2 = 4'(to_gray(mb[2])); e.b2 = 4'(mb[2]);
        e.w = {mwr[2], mwr[1], mwr[0]};
        e.o = {mo[2], mo[1], mo[0]};
        e.u = {mu[2], mu[1], mu[0]};
        return e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mb[i] = 0; mo[i] = 0; mu[i] = 0; mwr[i] = 0;
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int top = (1 << mw[i]) - 1;
            mwr[i] = 0;
            if (Clear_Flags) begin mo[i] = 0; mu[i] = 0; end
            if (Clr) mb[i] = 0;
            else if (Load) mb[i] = int'(lv) & top;
            else if (En && Up && mb[i] == top) begin
                mo[i] = 1;
                if (!ms[i]) begin mb[i] = 0; mwr[i] = 1; end
            end else if (En && !Up && mb[i] == 0) begin
                mu[i] = 1;
                if (!ms[i]) begin mb[i] = top; mwr[i] = 1; end
            end else if (En) mb[i] = Up ? mb[i] + 1 : mb[i] - 1;
        end
    endtask

    task automatic drive(input bit en, up, clr, ld, input int v, input bit cf);
        En = en; Up = up; Clr = clr; Load = ld; lv = 4'(v); Clear_Flags = cf;
        if (Reset_n) model_step(); else model_reset();
        sb.push_back(snap());
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic areset();
        #2;
        model_reset();
        sb.push_back(snap());
        Reset_n = 1'b0;
        @(negedge Clk);
        drive(0, 0, 0, 0, 0, 0);
        Reset_n = 1'b1;
    endtask

    task automatic chk(input string n, input logic [3:0] ag, ab, input logic aw, ao, au,
                       input logic [3:0] eg, eb, input logic ew, eo, eu);
        tests++;
        if ({ag, ab, aw, ao, au} !== {eg, eb, ew, eo, eu}) begin
            fails++;
            $display("FAIL %s @%0t: got gray=%h bin=%h wrap=%b ovf=%b unf=%b, want gray=%h bin=%h wrap=%b ovf=%b unf=%b",
                     n, $time, ag, ab, aw, ao, au, eg, eb, ew, eo, eu);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk or negedge Reset_n);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("w3_wrap", {1'b0, g0}, {1'b0, b0}, w0, o0, u0, e.g0, e.b0, e.w[0], e.o[0], e.u[0]);
                chk("w4_sat", g1, b1, w1, o1, u1, e.g1, e.b1, e.w[1], e.o[1], e.u[1]);
                chk("w4_wrap", g2, b2, w2, o2, u2, e.g2, e.b2, e.w[2], e.o[2], e.u[2]);
            end
        end
    end

    initial begin : stimulus
        @(negedge Clk);
        areset();
        repeat (9) drive(1, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        areset();
        repeat (4) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 14, 1);
        repeat (3) drive(1, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 15, 1);
        drive(1, 1, 1, 1, 9, 0);
        drive(0, 0, 0, 1, 9, 0);
        drive(0, 0, 0, 1, 15, 0);
        drive(1, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0);
        areset();
        repeat (5) drive(1, 1, 0, 0, 0, 0);
        areset();
        repeat (8) drive(1, 1, 0, 0, 0, 0);
        areset();
        repeat (3) drive(1, 1, 0, 0, 0, 0);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 63) == 0) areset();
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 7) == 0);
        end
        repeat (3) @(negedge Clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/gray_counter_n.md
# gray_counter_n

Parametrised Gray-code counter generalising the team's fixed 3-bit Gray counter. It counts up or down, supports synchronous clear and a parallel binary load, and offers an optional saturating mode. It reports wrap events as a one-cycle pulse and as sticky overflow/underflow flags. Gray and binary views of the count are exported as registered outputs for downstream sequencers and test harnesses.

## Interface
- WIDTH, 4, counter width in bits; legal range 2..16.
- SATURATE, 0, 0 = wrap at the end of the range; 1 = hold at the end of the range.
- Clk  input  1  rising-edge clock.
- Reset_n  input  1  asynchronous, active-low reset. Clears all state immediately; release is synchronised externally.
- En  input  1  count enable, sampled on the rising edge of Clk.
- Up  input  1  direction: 1 = increment, 0 = decrement. Only meaningful when En=1.
- Clr  input  1  synchronous clear of the count. Flags are not affected.
- Load  input  1  synchronous load of Load_Value.
- Load_Value  input  WIDTH  value to load, in plain binary.
- Clear_Flags  input  1  synchronous clear of Overflow and Underflow.
- Gray  output  WIDTH  registered Gray code of the count, equal to Binary ^ (Binary >> 1).
- Binary  output  WIDTH  registered binary count.
- Wrap  output  1  one-cycle pulse marking an actual wrap in either direction.
- Overflow  output  1  sticky flag: an increment was attempted at the maximum count.
- Underflow  output  1  sticky flag: a decrement was attempted at a count of 0.

## Operation
- Internal state is the binary count B plus the two flags. Gray is a register loaded with the Gray code of next-B on the same edge as B; it is never a combinational decode.
- Count update, per edge, in priority order:
  - Clr: B <= 0.
  - else Load: B <= Load_Value.
  - else En & Up: B <= B+1.
  - else En & ~Up: B <= B-1.
  - else hold.
- Up-end event: En & Up & ~Clr & ~Load & B == 2^WIDTH-1.
  - SATURATE=0: B <= 0 and Wrap pulses.
  - SATURATE=1: B holds at the maximum and Wrap stays low.
  - Either mode: Overflow <= 1.
- Down-end event: En & ~Up & ~Clr & ~Load & B == 0.
  - SATURATE=0: B <= 2^WIDTH-1 and Wrap pulses.
  - SATURATE=1: B holds at 0 and Wrap stays low.
  - Either mode: Underflow <= 1.
- Flags:
  - Set only by their end event.
  - Cleared by Clear_Flags or by reset.
  - If a set event and Clear_Flags occur on the same edge, the set wins and the flag reads 1.
- Clr and Load never set flags and never pulse Wrap, even when En=1 on the same edge.
- Arithmetic is modulo 2^WIDTH. No sign handling.
- Reset_n low: B=0, Gray=0, Binary=0, Wrap=0, Overflow=0, Underflow=0, taking effect asynchronously. This holds mid-count and mid-Wrap-pulse.

## Timing
- All outputs are registered. Each changes only on a rising edge of Clk, or asynchronously on assertion of Reset_n.
- Latency: inputs sampled at edge k are visible on the outputs after edge k. There are no combinational paths from inputs to outputs.
- Consecutive Gray values on successive counting edges differ in exactly one bit, including across a wrap.
- Wrap is high for exactly the one cycle following the wrapping edge. Back-to-back wraps (WIDTH=2 with a Up/Down toggle) give back-to-back pulses.
- With En=0 and no Clr/Load, all outputs hold indefinitely. Wrap returns to 0 after a single cycle.
- First edge after Reset_n deasserts: normal operation from B=0.

## Test plan
- WIDTH=3, SATURATE=0, Up=1, En=1 for 9 edges from reset:
  - Gray = 1,3,2,6,7,5,4,0,1.
  - Wrap high only in the cycle after the 8th edge.
  - Overflow goes to 1 at the 8th edge and stays 1.
- WIDTH=3, SATURATE=0, Up=0 from reset:
  - Gray = 4 after the 1st edge (Binary=7), then 5,7,6.
  - Underflow=1 and Wrap pulses once.
  - Clear_Flags for one edge returns Underflow to 0.
- WIDTH=4, SATURATE=1:
  - Load=1 with Load_Value=14, then Up counting: Binary 14,15,15,15.
  - Overflow=1 from the edge that attempts 15->16.
  - Wrap never asserts.
- Priority checks, WIDTH=4:
  - Clr, Load (Load_Value=9) and En all asserted at Binary=15, Up=1: Binary=0, no flag, no Wrap.
  - Next edge with only Load: Binary=9, Gray=13.
- Same-edge conflict: Clear_Flags asserted on the edge of an up-end event -> Overflow=1 afterwards.
- Async reset: drop Reset_n between edges mid-count (Binary=5) and during a Wrap pulse -> all outputs 0 immediately, without a clock edge; counting resumes from 0 after release.
